// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin encodings and values, the
// collector state enum and the money width that Main also uses.
package vm_pkg;

    localparam int MONEY_W = 7;

    typedef enum logic [1:0] {
        COIN_1  = 2'b00,
        COIN_2  = 2'b01,
        COIN_5  = 2'b10,
        COIN_10 = 2'b11
    } coin_e;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ORDER,
        WAIT,
        REFUND
    } state_e;

    function automatic logic [7:0] coin_value(input logic [1:0] t);
        logic [7:0] v;
        case (t)
            COIN_1:  v = 8'd1;
            COIN_2:  v = 8'd2;
            COIN_5:  v = 8'd5;
            default: v = 8'd10;
        endcase
        return v;
    endfunction

    // Largest denomination not exceeding amt; COIN_1 when amt is zero.
    function automatic logic [1:0] largest_coin(input logic [MONEY_W-1:0] amt);
        logic [1:0] t;
        if (amt >= 7'd10)      t = COIN_10;
        else if (amt >= 7'd5)  t = COIN_5;
        else if (amt >= 7'd2)  t = COIN_2;
        else                   t = COIN_1;
        return t;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Pays an amount back through the coin hopper, largest coin first, one coin
// per valid/ready handshake; o_done pulses once the remainder reaches zero.
module change_dispenser
    import vm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [MONEY_W-1:0] i_amount,
    output logic               o_coin_valid,
    output logic [1:0]         o_coin_type,
    input  logic               i_coin_ready,
    output logic               o_done
);

    logic [MONEY_W-1:0] r_refund_rem;
    logic               r_active;
    logic [1:0]         w_type;
    logic [7:0]         w_value;
    logic               w_empty;

    assign w_type  = largest_coin(r_refund_rem);
    assign w_value = coin_value(w_type);
    assign w_empty = (r_refund_rem == '0);

    // Type depends only on the remainder, so it holds while the hopper stalls.
    assign o_coin_valid = r_active && !w_empty;
    assign o_coin_type  = o_coin_valid ? w_type : 2'b00;
    assign o_done       = r_active && w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refund_rem <= '0;
            r_active     <= 1'b0;
        end else if (i_load) begin
            r_refund_rem <= i_amount;
            r_active     <= 1'b1;
        end else if (r_active) begin
            if (w_empty)
                r_active <= 1'b0;
            else if (i_coin_ready)
                r_refund_rem <= r_refund_rem - w_value[MONEY_W-1:0];
        end
    end

endmodule

// File: rtl/coin_credit_collector.sv
// Vending front end: collects coins into credit, offers the order to Main and
// pays change or refunds through change_dispenser.
// IDLE: no credit | COLLECT: accepting coins | ORDER: offering order |
// WAIT: Main busy | REFUND: paying out change/refund
module coin_credit_collector
    import vm_pkg::*;
#(
    parameter int MAX_CREDIT     = 127,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_valid,
    input  logic [1:0]         coin_type,
    input  logic               cancel,
    input  logic               buy_req,
    input  logic [2:0]         sel_type,
    input  logic [3:0]         sel_amount,
    output logic [MONEY_W-1:0] customer_money,
    output logic [2:0]         supply_type,
    output logic [3:0]         customer_amount,
    output logic               order_valid,
    input  logic               order_ready,
    input  logic               order_done,
    input  logic               order_error,
    input  logic [MONEY_W-1:0] change_in,
    output logic               coin_reject,
    output logic               coin_out_valid,
    output logic [1:0]         coin_out_type,
    input  logic               coin_out_ready,
    output logic               busy
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [MONEY_W-1:0] r_credit;
    logic [MONEY_W-1:0] w_credit_nxt;
    logic [2:0]         r_supply_type;
    logic [3:0]         r_customer_amount;
    logic               r_coin_reject;
    logic [TMR_W-1:0]   r_tmr;

    logic [7:0]         w_coin_val;
    logic [7:0]         w_sum;
    logic               w_fits;
    logic [MONEY_W-1:0] w_min_change;
    logic               w_coin_accept;
    logic               w_latch_sel;
    logic               w_tmr_reload;
    logic               w_tmr_dec;
    logic               w_disp_load;
    logic [MONEY_W-1:0] w_disp_amount;
    logic               w_disp_done;

    assign w_coin_val   = coin_value(coin_type);
    assign w_sum        = {1'b0, r_credit} + w_coin_val;
    assign w_fits       = (w_sum <= 8'(MAX_CREDIT));
    assign w_min_change = (change_in < r_credit) ? change_in : r_credit;

    always_comb begin
        w_state_nxt   = r_state;
        w_credit_nxt  = r_credit;
        w_coin_accept = 1'b0;
        w_latch_sel   = 1'b0;
        w_tmr_reload  = 1'b0;
        w_tmr_dec     = 1'b0;
        w_disp_load   = 1'b0;
        w_disp_amount = '0;
        case (r_state)
            IDLE: begin
                if (coin_valid && w_fits) begin
                    w_coin_accept = 1'b1;
                    w_credit_nxt  = w_sum[MONEY_W-1:0];
                    w_tmr_reload  = 1'b1;
                    w_state_nxt   = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    w_disp_load   = 1'b1;
                    w_disp_amount = r_credit;
                    w_state_nxt   = REFUND;
                end else begin
                    if (coin_valid && w_fits) begin
                        w_coin_accept = 1'b1;
                        w_credit_nxt  = w_sum[MONEY_W-1:0];
                        w_tmr_reload  = 1'b1;
                    end
                    // A coin in the buy cycle is already folded into w_credit_nxt.
                    if (buy_req && w_credit_nxt != '0) begin
                        w_latch_sel = 1'b1;
                        w_state_nxt = ORDER;
                    end else if (!coin_valid) begin
                        if (r_tmr == '0) begin
                            w_disp_load   = 1'b1;
                            w_disp_amount = r_credit;
                            w_state_nxt   = REFUND;
                        end else begin
                            w_tmr_dec = 1'b1;
                        end
                    end
                end
            end
            ORDER: begin
                if (order_ready) begin
                    w_state_nxt = WAIT;
                end else if (cancel) begin
                    w_disp_load   = 1'b1;
                    w_disp_amount = r_credit;
                    w_state_nxt   = REFUND;
                end
            end
            WAIT: begin
                if (order_done) begin
                    w_disp_load   = 1'b1;
                    w_disp_amount = order_error ? r_credit : w_min_change;
                    w_state_nxt   = REFUND;
                end
            end
            REFUND: begin
                if (w_disp_done) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= IDLE;
            r_credit          <= '0;
            r_supply_type     <= '0;
            r_customer_amount <= '0;
            r_coin_reject     <= 1'b0;
            r_tmr             <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_coin_reject <= coin_valid && !w_coin_accept;
            if (w_latch_sel) begin
                r_supply_type     <= sel_type;
                r_customer_amount <= sel_amount;
            end
            if (w_tmr_reload)
                r_tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
            else if (w_tmr_dec)
                r_tmr <= r_tmr - 1'b1;
        end
    end

    change_dispenser u_change_dispenser (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_disp_load),
        .i_amount     (w_disp_amount),
        .o_coin_valid (coin_out_valid),
        .o_coin_type  (coin_out_type),
        .i_coin_ready (coin_out_ready),
        .o_done       (w_disp_done)
    );

    assign customer_money  = r_credit;
    assign supply_type     = r_supply_type;
    assign customer_amount = r_customer_amount;
    assign coin_reject     = r_coin_reject;
    assign order_valid     = (r_state == ORDER);
    assign busy            = (r_state == ORDER) || (r_state == WAIT) || (r_state == REFUND);

endmodule

// File: tb/tb_coin_credit_collector.sv
// Self-checking bench for coin_credit_collector: directed scenarios plus
// randomized transactions against an arithmetic credit/refund model.
module tb_coin_credit_collector;

    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       cancel = 1'b0;
    logic       buy_req = 1'b0;
    logic [2:0] sel_type = 3'd0;
    logic [3:0] sel_amount = 4'd0;
    logic [6:0] customer_money;
    logic [2:0] supply_type;
    logic [3:0] customer_amount;
    logic       order_valid;
    logic       order_ready = 1'b0;
    logic       order_done = 1'b0;
    logic       order_error = 1'b0;
    logic [6:0] change_in = 7'd0;
    logic       coin_reject;
    logic       coin_out_valid;
    logic [1:0] coin_out_type;
    logic       coin_out_ready = 1'b0;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int vals[4] = '{1, 2, 5, 10};

    longint got_enc;
    int     stall_bad;
    bit     drain_to;

    coin_credit_collector #(
        .MAX_CREDIT(127), .TIMEOUT_CYCLES(TO), .TMR_W(10)
    ) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
        .cancel(cancel), .buy_req(buy_req), .sel_type(sel_type), .sel_amount(sel_amount),
        .customer_money(customer_money), .supply_type(supply_type),
        .customer_amount(customer_amount), .order_valid(order_valid),
        .order_ready(order_ready), .order_done(order_done), .order_error(order_error),
        .change_in(change_in), .coin_reject(coin_reject), .coin_out_valid(coin_out_valid),
        .coin_out_type(coin_out_type), .coin_out_ready(coin_out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Expected payout as a hex-nibble sequence, largest coin first.
    function automatic longint greedy_enc(input int amount);
        int     denoms[4] = '{10, 5, 2, 1};
        int     a = amount;
        longint e = 0;
        for (int i = 0; i < 4; i++)
            while (a >= denoms[i]) begin
                a -= denoms[i];
                e = e * 16 + longint'(denoms[i]);
            end
        return e;
    endfunction

    task automatic insert(input logic [1:0] t);
        coin_valid = 1'b1; coin_type = t;
        step();
        coin_valid = 1'b0;
    endtask

    // Plays the hopper until the DUT leaves busy; records coins and stalls.
    task automatic drain(input int stall_idx);
        int         idx = 0;
        int         budget = 300;
        int         hold = 0;
        logic [1:0] prev_t = 2'b00;
        bit         prev_wait = 1'b0;
        got_enc = 0; stall_bad = 0; drain_to = 1'b0;
        while (busy) begin
            if (budget == 0) begin drain_to = 1'b1; break; end
            budget--;
            if (prev_wait && coin_out_valid && coin_out_type !== prev_t) stall_bad++;
            if (idx == stall_idx && coin_out_valid && hold < 3) begin
                coin_out_ready = 1'b0; hold++;
            end else begin
                coin_out_ready = ($urandom_range(0, 3) != 0);
            end
            if (coin_out_valid && coin_out_ready) begin
                got_enc = got_enc * 16 + longint'(vals[coin_out_type]);
                idx++;
            end
            prev_wait = coin_out_valid && !coin_out_ready;
            prev_t = coin_out_type;
            step();
        end
        coin_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        n_vec++; if (customer_money !== 7'd0) begin n_err++; $display("FAIL reset_money: got %0d want 0", customer_money); end
        n_vec++; if ({order_valid, coin_out_valid, coin_reject, busy} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {order_valid, coin_out_valid, coin_reject, busy}); end
        n_vec++; if ({supply_type, customer_amount, coin_out_type} !== 9'd0) begin n_err++; $display("FAIL reset_latched: got %h want 0", {supply_type, customer_amount, coin_out_type}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_order();
        insert(2'b11); insert(2'b11);
        sel_type = 3'd3; sel_amount = 4'd2; buy_req = 1'b1;
        step();
        buy_req = 1'b0; sel_type = 3'd5; sel_amount = 4'd9;
        n_vec++; if (order_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", order_valid); end
        n_vec++; if (customer_money !== 7'd20) begin n_err++; $display("FAIL basic_money: got %0d want 20", customer_money); end
        step(2);
        n_vec++; if ({supply_type, customer_amount} !== {3'd3, 4'd2}) begin n_err++; $display("FAIL basic_sel: got %0d/%0d want 3/2", supply_type, customer_amount); end
        order_ready = 1'b1; step(); order_ready = 1'b0;
        n_vec++; if ({order_valid, busy} !== 2'b01) begin n_err++; $display("FAIL basic_wait: got %b want 01", {order_valid, busy}); end
        step(2);
        change_in = 7'd6; order_done = 1'b1; step(); order_done = 1'b0;
        drain(-1);
        n_vec++; if (got_enc !== greedy_enc(6) || drain_to) begin n_err++; $display("FAIL basic_change: got %h want %h", got_enc, greedy_enc(6)); end
        n_vec++; if ({busy, customer_money} !== 8'd0) begin n_err++; $display("FAIL basic_idle: got busy %b money %0d want 0/0", busy, customer_money); end
    endtask

    task automatic test_overflow();
        repeat (12) insert(2'b11);
        insert(2'b10);
        n_vec++; if (customer_money !== 7'd125) begin n_err++; $display("FAIL ovf_setup: got %0d want 125", customer_money); end
        insert(2'b10);
        n_vec++; if ({coin_reject, customer_money} !== {1'b1, 7'd125}) begin n_err++; $display("FAIL ovf_reject: got %b/%0d want 1/125", coin_reject, customer_money); end
        step();
        n_vec++; if (coin_reject !== 1'b0) begin n_err++; $display("FAIL ovf_pulse: got %b want 0", coin_reject); end
        insert(2'b01);
        n_vec++; if ({coin_reject, customer_money} !== {1'b0, 7'd127}) begin n_err++; $display("FAIL ovf_max: got %b/%0d want 0/127", coin_reject, customer_money); end
        cancel = 1'b1; step(); cancel = 1'b0;
        drain(-1);
        n_vec++; if (got_enc !== greedy_enc(127) || drain_to) begin n_err++; $display("FAIL ovf_refund: got %h want %h", got_enc, greedy_enc(127)); end
    endtask

    task automatic test_cancel_stall();
        insert(2'b11); insert(2'b10); insert(2'b01); insert(2'b00);
        cancel = 1'b1; step(); cancel = 1'b0;
        drain(1);
        n_vec++; if (got_enc !== greedy_enc(18) || drain_to) begin n_err++; $display("FAIL cancel_seq: got %h want %h", got_enc, greedy_enc(18)); end
        n_vec++; if (stall_bad !== 0) begin n_err++; $display("FAIL cancel_stable: got %0d type changes want 0", stall_bad); end
    endtask

    task automatic test_error_refund();
        insert(2'b10); insert(2'b01);
        buy_req = 1'b1; sel_type = 3'($urandom); sel_amount = 4'($urandom);
        step(); buy_req = 1'b0;
        order_ready = 1'b1; step(); order_ready = 1'b0;
        order_done = 1'b1; order_error = 1'b1; change_in = 7'd100;
        step();
        order_done = 1'b0; order_error = 1'b0;
        drain(-1);
        n_vec++; if (got_enc !== greedy_enc(7) || drain_to) begin n_err++; $display("FAIL error_refund: got %h want %h", got_enc, greedy_enc(7)); end
    endtask

    task automatic test_timeout();
        insert(2'b01); insert(2'b00);
        step(TO - 1);
        n_vec++; if ({busy, customer_money} !== {1'b0, 7'd3}) begin n_err++; $display("FAIL timeout_early: got busy %b money %0d want 0/3", busy, customer_money); end
        step();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL timeout_fire: got busy %b want 1", busy); end
        insert(2'b11);
        n_vec++; if ({coin_reject, customer_money} !== {1'b1, 7'd3}) begin n_err++; $display("FAIL refund_coin: got %b/%0d want 1/3", coin_reject, customer_money); end
        drain(-1);
        n_vec++; if (got_enc !== greedy_enc(3) || drain_to) begin n_err++; $display("FAIL timeout_refund: got %h want %h", got_enc, greedy_enc(3)); end
    endtask

    task automatic test_reset_mid_refund();
        insert(2'b10); insert(2'b01); insert(2'b00);
        cancel = 1'b1; step(); cancel = 1'b0;
        n_vec++; if ({coin_out_valid, coin_out_type} !== 3'b110) begin n_err++; $display("FAIL midrst_pre: got %b want 110", {coin_out_valid, coin_out_type}); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if ({coin_out_valid, busy, customer_money} !== 9'd0) begin n_err++; $display("FAIL midrst_async: got %b want 0", {coin_out_valid, busy, customer_money}); end
        step();
        reset = 1'b0;
        step();
        insert(2'b10);
        n_vec++; if ({busy, customer_money} !== {1'b0, 7'd5}) begin n_err++; $display("FAIL midrst_new: got busy %b money %0d want 0/5", busy, customer_money); end
        cancel = 1'b1; step(); cancel = 1'b0;
        drain(-1);
    endtask

    task automatic test_random_orders();
        for (int it = 0; it < 25; it++) begin
            int         m = 0;
            int         refund;
            int         choice;
            int         ncoins = $urandom_range(1, 16);
            logic [2:0] st;
            logic [3:0] sa;
            logic [1:0] t;
            bit         with_coin;
            bit         exp_rej;
            for (int c = 0; c < ncoins; c++) begin
                t = 2'($urandom);
                exp_rej = (m + vals[t] > 127);
                if (!exp_rej) m += vals[t];
                insert(t);
                n_vec++; if ({coin_reject, customer_money} !== {exp_rej, 7'(m)}) begin n_err++; $display("FAIL rnd_coin it%0d: got %b/%0d want %b/%0d", it, coin_reject, customer_money, exp_rej, m); end
                step($urandom_range(0, 2));
            end
            choice = $urandom_range(0, 2);
            t = 2'($urandom);
            with_coin = $urandom_range(0, 1) == 1;
            coin_valid = with_coin; coin_type = t;
            if (choice == 0) begin
                cancel = 1'b1; step(); cancel = 1'b0; coin_valid = 1'b0;
                refund = m;
                n_vec++; if (coin_reject !== with_coin) begin n_err++; $display("FAIL rnd_cancel_coin it%0d: got %b want %b", it, coin_reject, with_coin); end
            end else begin
                st = 3'($urandom); sa = 4'($urandom);
                sel_type = st; sel_amount = sa; buy_req = 1'b1;
                exp_rej = with_coin && (m + vals[t] > 127);
                if (with_coin && !exp_rej) m += vals[t];
                step(); buy_req = 1'b0; coin_valid = 1'b0; sel_type = ~st;
                n_vec++; if ({order_valid, customer_money, supply_type, customer_amount, coin_reject} !== {1'b1, 7'(m), st, sa, exp_rej}) begin
                    n_err++; $display("FAIL rnd_order it%0d: got v%b m%0d t%0d a%0d r%b want 1/%0d/%0d/%0d/%b", it, order_valid, customer_money, supply_type, customer_amount, coin_reject, m, st, sa, exp_rej);
                end
                order_done = 1'b1; step($urandom_range(1, 3)); order_done = 1'b0;
                n_vec++; if (order_valid !== 1'b1) begin n_err++; $display("FAIL rnd_hold it%0d: got %b want 1", it, order_valid); end
                if (choice == 2) begin
                    cancel = 1'b1; step(); cancel = 1'b0;
                    refund = m;
                end else begin
                    cancel = $urandom_range(0, 1) == 1;
                    order_ready = 1'b1; step(); order_ready = 1'b0; cancel = 1'b0;
                    step($urandom_range(0, 3));
                    n_vec++; if ({order_valid, busy, coin_out_valid} !== 3'b010) begin n_err++; $display("FAIL rnd_wait it%0d: got %b want 010", it, {order_valid, busy, coin_out_valid}); end
                    order_error = $urandom_range(0, 3) == 0;
                    change_in = 7'($urandom);
                    refund = order_error ? m : ((int'(change_in) < m) ? int'(change_in) : m);
                    order_done = 1'b1; step(); order_done = 1'b0; order_error = 1'b0;
                end
            end
            drain($urandom_range(0, 3));
            n_vec++; if (got_enc !== greedy_enc(refund) || drain_to) begin n_err++; $display("FAIL rnd_refund it%0d: got %h want %h", it, got_enc, greedy_enc(refund)); end
            n_vec++; if ({busy, customer_money} !== 8'd0) begin n_err++; $display("FAIL rnd_idle it%0d: got busy %b money %0d want 0/0", it, busy, customer_money); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_overflow();
        test_cancel_stall();
        test_error_refund();
        test_timeout();
        test_reset_mid_refund();
        test_random_orders();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
